nmu_cfg_loader: RTL and testbench
=================================

// Module: nmu_cfg_loader
// PURPOSE
// - AXI-Lite master that programs the NMU register file (config regs + CAM values) from an external entry table.
// - On start, replays NUM entries as single-beat writes; optional readback compares each entry after writing it.
// - Sits between the boot/management logic and the NMU AXI-Lite slave; reports done, error, failing index.
// PARAMETERS
// - ADDR_WIDTH   17   AXI-Lite address width (NMU register space)
// - DATA_WIDTH   32   AXI-Lite data width; wstrb is all-ones
// - MAX_ENTRIES  256  table depth; IDX_W = $clog2(MAX_ENTRIES)
// PORTS
// - aclk           in   1        clock, all logic rising-edge
// - areset         in   1        synchronous, active-high reset
// - start          in   1        pulse; sampled only in IDLE
// - num_entries    in   IDX_W+1  entry count (0..MAX_ENTRIES), latched at start
// - verify_en      in   1        readback-compare enable, latched at start
// - tbl_rd_en      out  1        table read strobe
// - tbl_idx        out  IDX_W    table index
// - tbl_addr       in   ADDR_W   entry address, valid 1 cycle after tbl_rd_en
// - tbl_data       in   DATA_W   entry data, valid 1 cycle after tbl_rd_en
// - m_axil_aw*/w*/b*/ar*/r*  --   standard AXI-Lite master; awprot/arprot = 0, wstrb = '1
// - busy           out  1        high from start accept to done
// - done           out  1        one-cycle pulse at end (success or error)
// - error          out  1        sticky until next accepted start
// - err_code       out  2        0 none, 1 BRESP!=OKAY, 2 RRESP!=OKAY, 3 readback mismatch
// - err_idx        out  IDX_W    index of failing entry
// BEHAVIOUR
// - Reset: all valids/readys, tbl_rd_en, busy, done, error = 0; err_code, err_idx, tbl_idx = 0; state IDLE.
// - FSM: IDLE -> FETCH -> LOAD -> WRITE -> WRESP -> [RADDR -> RDATA] -> NEXT -> FETCH | FIN -> IDLE.
// - IDLE: start=1 -> latch num_entries/verify_en, clear error, busy=1; if num_entries==0 go FIN directly.
// - FETCH: tbl_rd_en=1 one cycle with tbl_idx=current index. LOAD: register tbl_addr/tbl_data.
// - WRITE: awvalid and wvalid rise together; each drops independently on its own ready; exit when both accepted.
// - Same-cycle awready and wready allowed; addr/data stable while valid high.
// - WRESP: bready=1; on bvalid: bresp!=0 -> err 1, FIN; else RADDR if verify_en, else NEXT.
// - RADDR: arvalid until arready. RDATA: rready=1; rresp!=0 -> err 2; rdata!=written data -> err 3; else NEXT.
// - NEXT: index+1; index==num_entries-1 -> FIN, else FETCH. Index counter IDX_W+1 bits, no wrap.
// - FIN: done=1 for one cycle, busy=0 next cycle, return IDLE. Error aborts remaining entries.
// - Min per-entry latency without verify: 2 + handshakes (1-cycle-ready slave: 5 cycles/entry).
// - start while busy: ignored. start in FIN cycle: ignored.
// - areset mid-transaction: immediate return to reset values; valids may drop un-handshaken (slave shares reset).
// - err_idx captured on error only; holds value until next error.
// STRUCTURE
// - nmu_cfg_pkg: state enum (IDLE..FIN), err_code enum, AXI resp constant OKAY=2'b00.
// - Single module, no sub-module; aw/w acceptance tracked by two done-flags inside WRITE.
// TESTING
// - num_entries=3, verify=0, addrs 0x004/0x008/0x00C data 0xFFFFFFFF -> 3 writes in order, done pulse, error=0.
// - Slave asserts wready 2 cycles before awready -> wvalid drops first, single write per entry, no duplicate.
// - verify=1, slave returns rdata 0x0 for entry 1 of 4 -> err_code=3, err_idx=1, no entry 2/3 traffic, done pulse.
// - bresp=2'b10 on entry 0 -> err_code=1, err_idx=0, no AR issued; next start clears error.
// - num_entries=0 -> done within 2 cycles of start, no AXI valids; start during busy -> no effect.
// - areset asserted mid-WRITE -> next cycle all outputs at reset values; fresh start completes normally.

Source files
------------

// File: rtl/nmu_cfg_pkg.sv
// Shared types for the NMU configuration loader: FSM states, error codes, AXI response values.
package nmu_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_NEXT,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BRESP    = 2'd1,
    ERR_RRESP    = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_code_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/nmu_cfg_loader.sv
// Replays a table of (addr, data) entries into the NMU as AXI-Lite writes, optional readback check; 5 cycles/entry min.
// Waits indefinitely on every AXI handshake; the table is read one entry at a time, one cycle after tbl_rd_en.
module nmu_cfg_loader
  import nmu_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_ENTRIES = 256,
  parameter int IDX_W       = $clog2(MAX_ENTRIES)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [IDX_W:0]          num_entries,
  input  logic                    verify_en,
  output logic                    tbl_rd_en,
  output logic [IDX_W-1:0]        tbl_idx,
  input  logic [ADDR_WIDTH-1:0]   tbl_addr,
  input  logic [DATA_WIDTH-1:0]   tbl_data,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  input  logic [1:0]              m_axil_bresp,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [IDX_W-1:0]        err_idx
);

  localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_t                  state;
  err_code_t               err_q;
  logic [IDX_W:0]          idx;
  logic [IDX_W:0]          idx_nxt;
  logic [IDX_W:0]          num_q;
  logic                    verify_q;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    aw_fire;
  logic                    w_fire;

  assign aw_fire = m_axil_awvalid & m_axil_awready;
  assign w_fire  = m_axil_wvalid & m_axil_wready;
  assign idx_nxt = idx + IDX_ONE;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = data_q;
  assign m_axil_wstrb  = '1;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign err_code      = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= ST_IDLE;
      err_q          <= ERR_NONE;
      idx            <= '0;
      num_q          <= '0;
      verify_q       <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      tbl_rd_en      <= 1'b0;
      tbl_idx        <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_idx        <= '0;
    end else begin
      done      <= 1'b0;
      tbl_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q    <= num_entries;
            verify_q <= verify_en;
            error    <= 1'b0;
            err_q    <= ERR_NONE;
            busy     <= 1'b1;
            idx      <= '0;
            tbl_idx  <= '0;
            if (num_entries == '0) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              tbl_rd_en <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          addr_q         <= tbl_addr;
          data_q         <= tbl_data;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
          aw_done        <= 1'b0;
          w_done         <= 1'b0;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          // Address and data channels complete independently, in either order.
          if (aw_fire) begin
            m_axil_awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_fire) begin
            m_axil_wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            m_axil_bready <= 1'b1;
            state         <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            if (m_axil_bresp != AXI_OKAY) begin
              error   <= 1'b1;
              err_q   <= ERR_BRESP;
              err_idx <= idx[IDX_W-1:0];
              done    <= 1'b1;
              state   <= ST_FIN;
            end else if (verify_q) begin
              m_axil_arvalid <= 1'b1;
              state          <= ST_RADDR;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_RADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            if (m_axil_rresp != AXI_OKAY || m_axil_rdata != data_q) begin
              error   <= 1'b1;
              err_q   <= (m_axil_rresp != AXI_OKAY) ? ERR_RRESP : ERR_MISMATCH;
              err_idx <= idx[IDX_W-1:0];
              done    <= 1'b1;
              state   <= ST_FIN;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (idx == num_q - IDX_ONE) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            idx       <= idx_nxt;
            tbl_idx   <= idx_nxt[IDX_W-1:0];
            tbl_rd_en <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmu_cfg_loader.sv
// Bench for nmu_cfg_loader: behavioural AXI-Lite slave and table, expectations from an entry-level model.
module tb_nmu_cfg_loader;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int ME = 256;
  localparam int IW = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [IW:0]   num_entries;
  logic          verify_en;
  logic          tbl_rd_en;
  logic [IW-1:0] tbl_idx;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [IW-1:0] err_idx;

  always #5 aclk = ~aclk;

  nmu_cfg_loader dut (
    .aclk(aclk), .areset(areset), .start(start), .num_entries(num_entries),
    .verify_en(verify_en), .tbl_rd_en(tbl_rd_en), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
    .m_axil_awprot(awprot), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready), .m_axil_bresp(bresp), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata),
    .m_axil_rresp(rresp), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_idx(err_idx)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entry table: synchronous read, data valid the cycle after the strobe.
  logic [AW-1:0] tbl_a [ME];
  logic [DW-1:0] tbl_d [ME];
  always @(posedge aclk) begin
    if (tbl_rd_en) begin
      tbl_addr <= tbl_a[tbl_idx];
      tbl_data <= tbl_d[tbl_idx];
    end
  end

  // Slave configuration and observation state.
  int cfg_awd, cfg_wd, cfg_berr, cfg_rerr, cfg_corr;
  int w_commits, ar_seen;
  int done_cnt = 0, rd_strobes = 0, valid_cycles = 0, prot_bad = 0;
  logic [AW-1:0] aw_q[$], write_a[$];
  logic [DW-1:0] w_q[$], write_d[$], r_dat_q[$];
  logic [1:0]    b_resp_q[$], r_resp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  // AXI-Lite slave: decides readies/responses on the falling edge, so a handshake
  // seen here (valid && ready) completes on the following rising edge.
  initial begin
    int aw_wait, w_wait;
    bit b_fire, r_fire;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    aw_wait = 0; w_wait = 0; b_fire = 0; r_fire = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge aclk);
      if (done) done_cnt++;
      if (tbl_rd_en) rd_strobes++;
      if (awvalid || wvalid || arvalid) valid_cycles++;
      if (awprot != 3'b000 || arprot != 3'b000 || wstrb != 4'hF) prot_bad++;
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_q.delete(); w_q.delete(); b_resp_q.delete(); r_dat_q.delete(); r_resp_q.delete();
        aw_wait = 0; w_wait = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (b_fire) bvalid = 0;
        if (r_fire) rvalid = 0;
        if (!bvalid && b_resp_q.size() > 0) begin
          bvalid = 1; bresp = b_resp_q.pop_front();
        end
        if (!rvalid && r_dat_q.size() > 0) begin
          rvalid = 1; rdata = r_dat_q.pop_front(); rresp = r_resp_q.pop_front();
        end
        if (awvalid) begin
          if (aw_wait >= cfg_awd) begin awready = 1; aw_q.push_back(awaddr); aw_wait = 0; end
          else begin awready = 0; aw_wait++; end
        end else begin awready = 0; aw_wait = 0; end
        if (wvalid) begin
          if (w_wait >= cfg_wd) begin wready = 1; w_q.push_back(wdata); w_wait = 0; end
          else begin wready = 0; w_wait++; end
        end else begin wready = 0; w_wait = 0; end
        while (aw_q.size() > 0 && w_q.size() > 0) begin
          a = aw_q.pop_front(); d = w_q.pop_front();
          write_a.push_back(a); write_d.push_back(d); mem[a] = d;
          b_resp_q.push_back(w_commits == cfg_berr ? 2'b10 : 2'b00);
          w_commits++;
        end
        b_fire = bvalid && bready;
        if (arvalid) begin
          arready = 1;
          r_dat_q.push_back(ar_seen == cfg_corr ? '0 : mem[araddr]);
          r_resp_q.push_back(ar_seen == cfg_rerr ? 2'b10 : 2'b00);
          ar_seen++;
        end else arready = 0;
        r_fire = rvalid && rready;
      end
    end
  end

  int last_err_idx = 0;

  task automatic run_case(input string tag, input int n, input bit vfy, input int awd, input int wd,
                          input int berr, input int rerr, input int corr, input bit fixed, input bit poke);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int e_ar, e_code, e_idx, e_cyc, mx, d0, r0, v0, cyc;
    bit e_err;
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        tbl_a[i] = AW'(4 * (i + 1));
        tbl_d[i] = '1;
      end else begin
        tbl_a[i] = AW'((i << 2) | ($urandom_range(0, 31) << 12));
        tbl_d[i] = $urandom | 32'h1;
      end
    end
    cfg_awd = awd; cfg_wd = wd; cfg_berr = berr; cfg_rerr = rerr; cfg_corr = corr;
    w_commits = 0; ar_seen = 0;
    write_a.delete(); write_d.delete();

    // Entry-level reference: each entry costs fetch+load (2), the write phase
    // (slowest channel + 1), one response cycle, optional 2-cycle readback, then NEXT.
    mx = (awd > wd) ? awd : wd;
    e_ar = 0; e_err = 0; e_code = 0; e_idx = last_err_idx; e_cyc = 0;
    for (int i = 0; i < n; i++) begin
      ea.push_back(tbl_a[i]); ed.push_back(tbl_d[i]);
      e_cyc += 2 + (mx + 1) + 1;
      if (i == berr) begin e_err = 1; e_code = 1; e_idx = i; break; end
      if (vfy) begin
        e_ar++;
        e_cyc += 2;
        if (i == rerr) begin e_err = 1; e_code = 2; e_idx = i; break; end
        if (i == corr && tbl_d[i] != '0) begin e_err = 1; e_code = 3; e_idx = i; break; end
      end
      e_cyc += 1;
    end
    last_err_idx = e_idx;

    d0 = done_cnt; r0 = rd_strobes; v0 = valid_cycles;
    @(posedge aclk); #1;
    start = 1; num_entries = (IW + 1)'(n); verify_en = vfy;
    @(posedge aclk); #1;
    start = 0;
    check({tag, "_busy_on_start"}, 64'(busy), 64'(1));
    check({tag, "_error_cleared"}, 64'(error), 64'(0));
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (poke && cyc == 2) begin start = 1; num_entries = 9'd1; verify_en = ~vfy; end
      else start = 0;
      @(posedge aclk); #1;
      cyc++;
    end
    start = 0;
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(e_cyc));
    start = poke;
    @(posedge aclk); #1;
    start = 0;
    check({tag, "_idle_after_done"}, 64'({busy, done}), 64'(0));
    repeat (3) @(posedge aclk);
    #1;
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_table_reads"}, 64'(rd_strobes - r0), 64'(ea.size()));
    check({tag, "_write_count"}, 64'(write_a.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < write_a.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 64'(write_a[i]), 64'(ea[i]));
      check($sformatf("%s_wr%0d_data", tag, i), 64'(write_d[i]), 64'(ed[i]));
    end
    check({tag, "_leftover_aw_w"}, 64'(aw_q.size() + w_q.size()), 64'(0));
    check({tag, "_read_count"}, 64'(ar_seen), 64'(e_ar));
    check({tag, "_error"}, 64'(error), 64'(e_err));
    check({tag, "_err_code"}, 64'(err_code), 64'(e_code));
    check({tag, "_err_idx"}, 64'(err_idx), 64'(e_idx));
    if (n == 0) check({tag, "_no_valids"}, 64'(valid_cycles - v0), 64'(0));
  endtask

  initial begin
    int n, sel, cyc;
    areset = 1; start = 0; num_entries = '0; verify_en = 0;
    cfg_awd = 0; cfg_wd = 0; cfg_berr = -1; cfg_rerr = -1; cfg_corr = -1;
    w_commits = 0; ar_seen = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, tbl_rd_en}), 64'(0));
    check("rst_status", 64'({busy, done, error}), 64'(0));
    check("rst_codes", 64'({err_code, err_idx, tbl_idx}), 64'(0));
    areset = 0;

    run_case("basic3",     3,   0, 0, 0, -1, -1, -1, 1, 0);
    run_case("aw_late",    4,   0, 2, 0, -1, -1, -1, 0, 1);
    run_case("bresp0",     3,   1, 0, 0,  0, -1, -1, 0, 0);
    run_case("mism1",      4,   1, 0, 0, -1, -1,  1, 0, 0);
    run_case("clean",      5,   1, 1, 0, -1, -1, -1, 0, 0);
    run_case("zero",       0,   0, 0, 0, -1, -1, -1, 0, 1);
    run_case("rresp2",     5,   1, 0, 1, -1,  2, -1, 0, 0);
    run_case("w_late",     3,   1, 0, 3, -1, -1, -1, 0, 1);
    run_case("full",       ME,  0, 0, 0, -1, -1, -1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 12);
      sel = $urandom_range(0, 3);
      run_case($sformatf("rand%0d", k), n, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3),
               sel == 1 ? $urandom_range(0, n - 1) : -1,
               sel == 2 ? $urandom_range(0, n - 1) : -1,
               sel == 3 ? $urandom_range(0, n - 1) : -1, 0, 0);
    end

    // Reset while the write address is still waiting for its ready.
    cfg_awd = 3; cfg_wd = 0; cfg_berr = -1; cfg_rerr = -1; cfg_corr = -1;
    @(posedge aclk); #1;
    start = 1; num_entries = 9'd3; verify_en = 1;
    @(posedge aclk); #1;
    start = 0;
    cyc = 0;
    while (!awvalid && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    check("midrst_in_write", 64'(awvalid), 64'(1));
    areset = 1;
    @(posedge aclk); #1;
    check("midrst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, tbl_rd_en}), 64'(0));
    check("midrst_status", 64'({busy, done, error}), 64'(0));
    check("midrst_codes", 64'({err_code, err_idx, tbl_idx}), 64'(0));
    areset = 0;
    last_err_idx = 0;
    run_case("post_rst",   4,   1, 1, 2, -1, -1, -1, 0, 0);

    check("prot_strb_constant", 64'(prot_bad), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
